// File: rtl/walk_register.sv
// Pedestrian walk-request latch: detects button requests, holds the request flag until the
// controller clears it, and counts requests accepted since the last clear.
module walk_register #(
    parameter int EDGE_MODE = 1,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WR_Sync,
    input  logic             WR_Reset,
    output logic             WR,
    output logic             WR_Rise,
    output logic [CNT_W-1:0] WR_Count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_prev_q, sync_prev_d;
    logic             wr_q, wr_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             req;

    always_comb begin
        req         = (EDGE_MODE != 0) ? (WR_Sync & ~sync_prev_q) : WR_Sync;
        sync_prev_d = WR_Sync;
        wr_d        = wr_q;
        count_d     = count_q;

        // Set wins over clear so a request arriving with the clear is never lost.
        if (req) begin
            wr_d = 1'b1;
            if (WR_Reset) begin
                count_d = CNT_ONE;
            end else if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_ONE;
            end
        end else if (WR_Reset) begin
            wr_d    = 1'b0;
            count_d = '0;
        end

        rise_d = wr_d & ~wr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_prev_q <= 1'b0;
            wr_q        <= 1'b0;
            rise_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            sync_prev_q <= sync_prev_d;
            wr_q        <= wr_d;
            rise_q      <= rise_d;
            count_q     <= count_d;
        end
    end

    assign WR       = wr_q;
    assign WR_Rise  = rise_q;
    assign WR_Count = count_q;

endmodule

// File: tb/tb_walk_register.sv
// Directed bench for walk_register: an edge-mode and a level-mode instance share stimulus.
module tb_walk_register;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       WR_Sync;
    logic       WR_Reset;
    logic       wr_e, rise_e;
    logic [3:0] count_e;
    logic       wr_l, rise_l;
    logic [3:0] count_l;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    walk_register #(.EDGE_MODE(1), .CNT_W(4)) dut_e (
        .clk      (clk),
        .rst_n    (rst_n),
        .WR_Sync  (WR_Sync),
        .WR_Reset (WR_Reset),
        .WR       (wr_e),
        .WR_Rise  (rise_e),
        .WR_Count (count_e)
    );

    walk_register #(.EDGE_MODE(0), .CNT_W(4)) dut_l (
        .clk      (clk),
        .rst_n    (rst_n),
        .WR_Sync  (WR_Sync),
        .WR_Reset (WR_Reset),
        .WR       (wr_l),
        .WR_Rise  (rise_l),
        .WR_Count (count_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_e(input string tag, input logic w, input logic r, input logic [3:0] c);
        check({tag, ".wr"},    32'(wr_e),    32'(w));
        check({tag, ".rise"},  32'(rise_e),  32'(r));
        check({tag, ".count"}, 32'(count_e), 32'(c));
    endtask

    initial begin
        rst_n    = 1'b0;
        WR_Sync  = 1'b0;
        WR_Reset = 1'b0;
        tick();
        tick();
        check_e("reset", 1'b0, 1'b0, 4'd0);
        rst_n = 1'b1;
        tick();
        check_e("idle", 1'b0, 1'b0, 4'd0);

        // single-cycle press
        WR_Sync = 1'b1;
        tick();
        check_e("press", 1'b1, 1'b1, 4'd1);
        WR_Sync = 1'b0;
        tick();
        check_e("press_after", 1'b1, 1'b0, 4'd1);
        for (int i = 0; i < 10; i++) tick();
        check_e("hold10", 1'b1, 1'b0, 4'd1);

        // clear
        WR_Reset = 1'b1;
        tick();
        check_e("clear", 1'b0, 1'b0, 4'd0);

        // held clear, then a request while clear still asserted
        tick();
        tick();
        check_e("held_clear", 1'b0, 1'b0, 4'd0);
        WR_Sync = 1'b1;
        tick();
        check_e("set_over_clear", 1'b1, 1'b1, 4'd1);
        WR_Sync  = 1'b0;
        WR_Reset = 1'b0;
        tick();
        check_e("set_over_clear_after", 1'b1, 1'b0, 4'd1);

        // second press while WR already set, then simultaneous press and clear
        WR_Sync = 1'b1;
        tick();
        check_e("second_press", 1'b1, 1'b0, 4'd2);
        WR_Sync = 1'b0;
        tick();
        WR_Sync  = 1'b1;
        WR_Reset = 1'b1;
        tick();
        check_e("simul_wr_set", 1'b1, 1'b0, 4'd1);
        WR_Sync  = 1'b0;
        WR_Reset = 1'b0;
        tick();

        // held-high button: edge mode counts once, level mode counts every cycle
        WR_Reset = 1'b1;
        tick();
        WR_Reset = 1'b0;
        check("lvl_cleared", 32'(count_l), 32'd0);
        WR_Sync = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        WR_Sync = 1'b0;
        tick();
        check_e("held_edge", 1'b1, 1'b0, 4'd1);
        check("held_level.count", 32'(count_l), 32'd5);
        check("held_level.wr",    32'(wr_l),    32'd1);

        // saturation over 20 presses
        WR_Reset = 1'b1;
        tick();
        WR_Reset = 1'b0;
        for (int p = 1; p <= 20; p++) begin
            WR_Sync = 1'b1;
            tick();
            WR_Sync = 1'b0;
            tick();
            if (p == 14) check("sat.p14", 32'(count_e), 32'd14);
            if (p == 15) check("sat.p15", 32'(count_e), 32'd15);
        end
        check_e("sat20", 1'b1, 1'b0, 4'd15);
        check("sat20_level", 32'(count_l), 32'd15);

        // reset mid-operation with the button held, then release with it still held
        WR_Sync = 1'b1;
        rst_n   = 1'b0;
        tick();
        check_e("mid_reset", 1'b0, 1'b0, 4'd0);
        check("mid_reset_level", 32'(count_l), 32'd0);
        rst_n = 1'b1;
        tick();
        check_e("release_edge", 1'b1, 1'b1, 4'd1);
        WR_Sync = 1'b0;
        tick();
        check_e("release_after", 1'b1, 1'b0, 4'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
